branch_resolve_unit: RTL

Execute-stage consumer of the branch decoder's output fields. It takes a decoded conditional branch (rs1/rs2 operand values, 12-bit B-immediate, 3-bit branch control) together with its PC and the fetch-stage prediction. It evaluates the condition and computes the target, then reports whether fetch must be redirected. The block is a two-stage valid/ready pipeline sitting between decode/register-read and the PC-redirect/flush logic.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_compare.sv | 29 ++
 rtl/branch_resolve_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions for the decoder and the execute-stage resolve unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_pkg;

    // 3-bit branch control produced by the decoder; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5
    } branch_ctrl_t;

    // Fall-through distance for a 32-bit instruction.
    localparam int unsigned BRANCH_LINK_OFFSET = 4;

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator: ctrl, a, b -> taken.
// Latency: purely combinational.
// Backpressure: none; illegal control codes evaluate to not-taken.
// Ports: ctrl_i (branch control code), a_i/b_i (operands), taken_o (condition true).
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (ctrl_i)
            BR_BEQ:  taken_o = (a_i == b_i);
            BR_BNE:  taken_o = (a_i != b_i);
            BR_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
            BR_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
            BR_BLTU: taken_o = (a_i <  b_i);
            BR_BGEU: taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates condition, computes target, reports fetch redirect.
// Latency: 2 cycles from input transfer edge to out_valid (S1 capture, S2 register).
// Backpressure: valid/ready; S2 holds while out_valid && !out_ready, S1 then holds and in_ready drops.
// Ports: clk/rst_n; in_* branch request (pc, operands, imm[12:1], control, prediction) with in_valid/in_ready;
//        flush kills both stages; out_* registered result (taken, target, redirect, redirect_pc, misaligned)
//        with out_valid/out_ready.
// Optional: define BRANCH_RESOLVE_STATS_EN to add saturating stat_branches / stat_mispredicts counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [12:1]     in_imm,
    input  logic [2:0]      in_branch_control,
    input  logic            in_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_misaligned
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    // ---------------- Stage 1 registers ----------------
    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_pc_q;
    logic [XLEN-1:0] s1_rs1_q;
    logic [XLEN-1:0] s1_rs2_q;
    logic [12:1]     s1_imm_q;
    logic [2:0]      s1_ctrl_q;
    logic            s1_pred_q;

    // ---------------- Stage 2 registers ----------------
    logic            s2_valid_q, s2_valid_d;
    logic            s2_taken_q;
    logic [XLEN-1:0] s2_target_q;
    logic            s2_redirect_q;
    logic [XLEN-1:0] s2_redirect_pc_q;
    logic            s2_misaligned_q;

    // ---------------- Handshake ----------------
    logic s2_load;
    logic in_fire;
    logic out_fire;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !flush && (!s1_valid_q || s2_load);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // flush wins over everything; a refill and a drain may happen in the same cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush)
            s1_valid_d = 1'b0;
        else if (in_fire)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (flush)
            s2_valid_d = 1'b0;
        else if (s2_load)
            s2_valid_d = 1'b1;
        else if (out_ready)
            s2_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
            s1_ctrl_q  <= '0;
            s1_pred_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_pc_q   <= in_pc;
                s1_rs1_q  <= in_rs1_data;
                s1_rs2_q  <= in_rs2_data;
                s1_imm_q  <= in_imm;
                s1_ctrl_q <= in_branch_control;
                s1_pred_q <= in_pred_taken;
            end
        end
    end

    // ---------------- Stage 1 combinational resolve ----------------
    logic            s1_taken;
    logic [XLEN-1:0] s1_offset;
    logic [XLEN-1:0] s1_target;
    logic [XLEN-1:0] s1_fallthru;
    logic            s1_redirect;
    logic [XLEN-1:0] s1_redirect_pc;
    logic            s1_misaligned;

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .ctrl_i  (s1_ctrl_q),
        .a_i     (s1_rs1_q),
        .b_i     (s1_rs2_q),
        .taken_o (s1_taken)
    );

    // B-immediate is a 13-bit signed byte offset with an implicit zero LSB.
    assign s1_offset      = {{(XLEN-13){s1_imm_q[12]}}, s1_imm_q, 1'b0};
    assign s1_target      = s1_pc_q + s1_offset;
    assign s1_fallthru    = s1_pc_q + XLEN'(BRANCH_LINK_OFFSET);
    assign s1_redirect    = s1_taken != s1_pred_q;
    assign s1_redirect_pc = s1_taken ? s1_target : s1_fallthru;
    // Only a taken branch can fault on its target; bit 0 is always zero here.
    assign s1_misaligned  = s1_taken && s1_target[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q       <= 1'b0;
            s2_taken_q       <= 1'b0;
            s2_target_q      <= '0;
            s2_redirect_q    <= 1'b0;
            s2_redirect_pc_q <= '0;
            s2_misaligned_q  <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load && !flush) begin
                s2_taken_q       <= s1_taken;
                s2_target_q      <= s1_target;
                s2_redirect_q    <= s1_redirect;
                s2_redirect_pc_q <= s1_redirect_pc;
                s2_misaligned_q  <= s1_misaligned;
            end
        end
    end

    assign out_valid       = s2_valid_q;
    assign out_taken       = s2_taken_q;
    assign out_target      = s2_target_q;
    assign out_redirect    = s2_redirect_q;
    assign out_redirect_pc = s2_redirect_pc_q;
    assign out_misaligned  = s2_misaligned_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    // Saturating event counters; only reset clears them, flush does not.
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (out_fire) begin
            if (stat_branches_q != 32'hFFFF_FFFF)
                stat_branches_d = stat_branches_q + 32'd1;
            if (s2_redirect_q && (stat_mispredicts_q != 32'hFFFF_FFFF))
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    // Output handshake is consumed by the counters only when they exist.
    logic unused_out_fire;
    assign unused_out_fire = out_fire;
`endif

endmodule
